// File: rtl/axi4_burst_checker.sv
// AXI4 burst master: writes NUM_BURSTS INCR bursts of an address-derived pattern, reads them
// back and counts response/data/rlast errors. Define AXI_ID_EN to add ID ports and ID checks.

module axi4_burst_checker #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 64,
  parameter int                ID_W       = 2,
  parameter int                BURST_LEN  = 8,
  parameter int                NUM_BURSTS = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
`ifdef AXI_ID_EN
  output logic [ID_W-1:0]       awid,
  output logic [ID_W-1:0]       arid,
  input  logic [ID_W-1:0]       bid,
  input  logic [ID_W-1:0]       rid,
`endif
  output logic [ADDR_W-1:0]     awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ADDR_W-1:0]     araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready
);

  localparam int BYTES       = DATA_W / 8;
  localparam int LANES       = DATA_W / 32;
  localparam int BURST_BYTES = BURST_LEN * BYTES;
  localparam int BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int K_BITS      = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  // k is at least ID_W wide so its low bits can be used directly as the transaction ID
  localparam int K_W         = (K_BITS > ID_W) ? K_BITS : ID_W;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [K_W-1:0]    LAST_K    = K_W'(NUM_BURSTS - 1);
  localparam logic [7:0]        AX_LEN    = 8'(BURST_LEN - 1);
  localparam logic [2:0]        AX_SIZE   = 3'($clog2(BYTES));

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [15:0]         err_q, err_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                busy_q, busy_d;

  logic [ADDR_W-1:0]   burst_addr;
  logic [ADDR_W-1:0]   beat_addr;
  logic [31:0]         beat_addr32;
  logic [DATA_W-1:0]   pattern;
  logic [2:0]          err_inc;
  logic [16:0]         err_sum;
  logic [15:0]         err_sat;
  logic                b_hs, r_hs;

  assign burst_addr = BASE_ADDR + ADDR_W'(k_q) * ADDR_W'(BURST_BYTES);
  assign beat_addr  = burst_addr + ADDR_W'(beat_q) * ADDR_W'(BYTES);

  if (ADDR_W >= 32) begin : g_addr_wide
    assign beat_addr32 = beat_addr[31:0];
  end else begin : g_addr_narrow
    assign beat_addr32 = {{(32-ADDR_W){1'b0}}, beat_addr};
  end

  // One pattern generator serves both the write data and the read-back expectation
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign pattern[gi*32 +: 32] = (beat_addr32 + 32'(4 * gi)) ^ 32'hA5A5_A5A5;
  end

  assign b_hs = (state_q == S_B) && bvalid;
  assign r_hs = (state_q == S_R) && rvalid;

  always_comb begin
    err_inc = 3'd0;
    if (b_hs) begin
      if (bresp != 2'b00) err_inc = err_inc + 3'd1;
`ifdef AXI_ID_EN
      if (bid != k_q[ID_W-1:0]) err_inc = err_inc + 3'd1;
`endif
    end
    if (r_hs) begin
      if (rresp != 2'b00)            err_inc = err_inc + 3'd1;
      if (rdata != pattern)          err_inc = err_inc + 3'd1;
      if (rlast != (beat_q == LAST_BEAT)) err_inc = err_inc + 3'd1;
`ifdef AXI_ID_EN
      if (rid != k_q[ID_W-1:0])      err_inc = err_inc + 3'd1;
`endif
    end
  end

  assign err_sum = {1'b0, err_q} + 17'(err_inc);
  assign err_sat = err_sum[16] ? 16'hFFFF : err_sum[15:0];

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    beat_d  = beat_q;
    err_d   = err_q;
    done_d  = done_q;
    pass_d  = pass_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_AW;
          k_d     = '0;
          beat_d  = '0;
          err_d   = 16'd0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_AW: begin
        if (awready) begin
          state_d = S_W;
          beat_d  = '0;
        end
      end
      S_W: begin
        if (wready) begin
          if (beat_q == LAST_BEAT) begin
            state_d = S_B;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      S_B: begin
        if (bvalid) begin
          err_d = err_sat;
          if (k_q == LAST_K) begin
            state_d = S_AR;
            k_d     = '0;
          end else begin
            state_d = S_AW;
            k_d     = k_q + K_W'(1);
          end
        end
      end
      S_AR: begin
        if (arready) begin
          state_d = S_R;
          beat_d  = '0;
        end
      end
      S_R: begin
        if (rvalid) begin
          err_d = err_sat;
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            if (k_q == LAST_K) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              pass_d  = (err_sat == 16'd0);
            end else begin
              state_d = S_AR;
              k_d     = k_q + K_W'(1);
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      beat_q  <= '0;
      err_q   <= 16'd0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
    end
  end

  // Channel fields are forced to zero outside their owning state
  logic aw_act, w_act, ar_act;
  assign aw_act = (state_q == S_AW);
  assign w_act  = (state_q == S_W);
  assign ar_act = (state_q == S_AR);

  assign awvalid = aw_act;
  assign awaddr  = aw_act ? burst_addr : '0;
  assign awlen   = aw_act ? AX_LEN : 8'd0;
  assign awsize  = aw_act ? AX_SIZE : 3'd0;
  assign awburst = aw_act ? 2'b01 : 2'b00;
  assign awlock  = 1'b0;
  assign awcache = aw_act ? 4'b0011 : 4'b0000;
  assign awprot  = 3'b000;

  assign wvalid  = w_act;
  assign wdata   = w_act ? pattern : '0;
  assign wstrb   = {BYTES{w_act}};
  assign wlast   = w_act && (beat_q == LAST_BEAT);
  assign bready  = (state_q == S_B);

  assign arvalid = ar_act;
  assign araddr  = ar_act ? burst_addr : '0;
  assign arlen   = ar_act ? AX_LEN : 8'd0;
  assign arsize  = ar_act ? AX_SIZE : 3'd0;
  assign arburst = ar_act ? 2'b01 : 2'b00;
  assign arlock  = 1'b0;
  assign arcache = ar_act ? 4'b0011 : 4'b0000;
  assign arprot  = 3'b000;
  assign rready  = (state_q == S_R);

`ifdef AXI_ID_EN
  assign awid = aw_act ? k_q[ID_W-1:0] : '0;
  assign arid = ar_act ? k_q[ID_W-1:0] : '0;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_axi4_burst_checker.sv
// Bench for axi4_burst_checker: memory-backed AXI slave with fault knobs, expectation queues
// filled per run from an address-level model, and a separate negedge monitor that compares.
`timescale 1ns/1ps
module tb_axi4_burst_checker;

  localparam int          DW    = 64;
  localparam int          BL    = 4;
  localparam int          NB    = 2;
  localparam int          IDW   = 2;
  localparam int          BYTES = DW / 8;
  localparam int          BB    = BL * BYTES;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic            busy, done, pass;
  logic [15:0]     err_count;
  logic [31:0]     awaddr, araddr;
  logic [7:0]      awlen, arlen;
  logic [2:0]      awsize, arsize, awprot, arprot;
  logic [1:0]      awburst, arburst, bresp, rresp;
  logic            awlock, arlock;
  logic [3:0]      awcache, arcache;
  logic            awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic            arvalid, arready, rvalid, rready, rlast;
  logic [DW-1:0]   wdata, rdata;
  logic [BYTES-1:0] wstrb;
`ifdef AXI_ID_EN
  logic [IDW-1:0]  awid, arid, bid, rid;
`endif

  axi4_burst_checker #(
    .ADDR_W(32), .DATA_W(DW), .ID_W(IDW), .BURST_LEN(BL), .NUM_BURSTS(NB), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count),
`ifdef AXI_ID_EN
    .awid(awid), .arid(arid), .bid(bid), .rid(rid),
`endif
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic void miss(string name);
    checks++;
    errors++;
    $display("FAIL %s actual=unexpected_or_timeout required=expected_event", name);
  endfunction

  // Spec rule: each 32-bit lane i of the beat at byte address a is (a + 4i) ^ A5A5A5A5
  function automatic logic [DW-1:0] model_beat(input logic [31:0] a);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = (a + 32'(4 * i)) ^ 32'hA5A5_A5A5;
    return v;
  endfunction

  typedef struct packed { logic [DW-1:0] data; logic last; } wexp_t;
  typedef struct packed { logic [15:0] err; logic pass; } res_t;
  logic [31:0] aw_q[$];
  logic [31:0] ar_q[$];
  wexp_t       w_q[$];
  res_t        res_q[$];

  // Slave fault knobs
  bit stall_en = 0, corrupt_en = 0, badresp_en = 0, badid_en = 0;

  logic [DW-1:0] mem [logic [31:0]];
  logic [31:0]   s_waddr = '0, s_raddr = '0;
  int            s_wbeat = 0, s_rbeat = 0;
  bit            s_bpend = 0, s_ractive = 0;
`ifdef AXI_ID_EN
  logic [IDW-1:0] s_awid = '0, s_arid = '0;
`endif

  function automatic bit rnd();
    return stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
  endfunction

  task automatic slave_reset();
    awready = 0; wready = 0; arready = 0;
    bvalid = 0; bresp = 0; rvalid = 0; rdata = '0; rresp = 0; rlast = 0;
`ifdef AXI_ID_EN
    bid = '0; rid = '0;
`endif
    s_bpend = 0; s_ractive = 0; s_wbeat = 0; s_rbeat = 0;
  endtask

  // Memory-backed slave: capture handshakes at negedge, update drives just after posedge
  initial begin
    logic c_aw, c_w, c_b, c_ar, c_r;
    logic [31:0] c_awaddr, c_araddr;
    logic [DW-1:0] c_wdata;
    logic [31:0] key;
    int rb;
`ifdef AXI_ID_EN
    logic [IDW-1:0] c_awid, c_arid;
`endif
    slave_reset();
    forever begin
      @(negedge clk);
      c_aw = awvalid && awready; c_awaddr = awaddr;
      c_w  = wvalid && wready;   c_wdata  = wdata;
      c_b  = bvalid && bready;
      c_ar = arvalid && arready; c_araddr = araddr;
      c_r  = rvalid && rready;
`ifdef AXI_ID_EN
      c_awid = awid; c_arid = arid;
`endif
      @(posedge clk);
      #1;
      if (!rst_n) begin
        slave_reset();
        continue;
      end
      if (c_aw) begin
        s_waddr = c_awaddr; s_wbeat = 0;
`ifdef AXI_ID_EN
        s_awid = c_awid;
`endif
      end
      if (c_w) begin
        mem[s_waddr + 32'(s_wbeat * BYTES)] = c_wdata;
        s_wbeat++;
        if (s_wbeat == BL) s_bpend = 1;
      end
      if (c_b) bvalid = 0;
      if (c_ar) begin
        s_raddr = c_araddr; s_rbeat = 0; s_ractive = 1;
`ifdef AXI_ID_EN
        s_arid = c_arid;
`endif
      end
      if (c_r) begin
        rvalid = 0;
        s_rbeat++;
        if (s_rbeat == BL) s_ractive = 0;
      end
      awready = rnd();
      wready  = rnd();
      arready = rnd();
      if (s_bpend && !bvalid && rnd()) begin
        bvalid  = 1;
        bresp   = badresp_en ? 2'b10 : 2'b00;
        s_bpend = 0;
`ifdef AXI_ID_EN
        bid = (badid_en && s_waddr == BASE) ? 2'b11 : s_awid;
`endif
      end
      if (s_ractive && !rvalid && rnd()) begin
        key    = s_raddr + 32'(s_rbeat * BYTES);
        rb     = int'((s_raddr - BASE) / BB);
        rvalid = 1;
        rdata  = mem.exists(key) ? mem[key] : '0;
        if (corrupt_en && rb == 1 && s_rbeat == 2) rdata[0] = ~rdata[0];
        rresp  = badresp_en ? 2'b10 : 2'b00;
        rlast  = (s_rbeat == BL - 1);
`ifdef AXI_ID_EN
        rid = s_arid;
`endif
      end
    end
  end

  // Monitor: pops the expectation queues whenever the DUT completes a handshake
  initial begin
    bit aw_hold, w_hold, ar_hold, done_prev;
    logic [31:0] aw_held, ar_held, e;
    logic [DW-1:0] w_held;
    wexp_t we;
    res_t re;
    aw_hold = 0; w_hold = 0; ar_hold = 0; done_prev = 0;
    aw_held = '0; ar_held = '0; w_held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_hold = 0; w_hold = 0; ar_hold = 0; done_prev = 0;
        continue;
      end
      if (aw_hold) chk("aw_stable", 128'({awvalid, awaddr}), 128'({1'b1, aw_held}));
      if (w_hold)  chk("w_stable", 128'({wvalid, wdata}), 128'({1'b1, w_held}));
      if (ar_hold) chk("ar_stable", 128'({arvalid, araddr}), 128'({1'b1, ar_held}));
      aw_hold = awvalid && !awready; aw_held = awaddr;
      w_hold  = wvalid && !wready;   w_held  = wdata;
      ar_hold = arvalid && !arready; ar_held = araddr;

      if (awvalid && awready) begin
        if (aw_q.size() == 0) miss("aw_unexpected");
        else begin
          e = aw_q.pop_front();
          $display("AW  addr=%08h len=%0d size=%0d", awaddr, awlen, awsize);
          chk("awaddr", 128'(awaddr), 128'(e));
          chk("aw_ctrl", 128'({awlen, awsize, awburst, awlock, awcache, awprot}),
              128'({8'(BL - 1), 3'd3, 2'b01, 1'b0, 4'b0011, 3'b000}));
`ifdef AXI_ID_EN
          chk("awid", 128'(awid), 128'(IDW'((e - BASE) / BB)));
`endif
        end
      end
      if (wvalid && wready) begin
        if (w_q.size() == 0) miss("w_unexpected");
        else begin
          we = w_q.pop_front();
          chk("wdata", 128'(wdata), 128'(we.data));
          chk("wlast_wstrb", 128'({wlast, wstrb}), 128'({we.last, {BYTES{1'b1}}}));
        end
      end
      if (arvalid && arready) begin
        if (ar_q.size() == 0) miss("ar_unexpected");
        else begin
          e = ar_q.pop_front();
          $display("AR  addr=%08h len=%0d size=%0d", araddr, arlen, arsize);
          chk("araddr", 128'(araddr), 128'(e));
          chk("ar_ctrl", 128'({arlen, arsize, arburst, arlock, arcache, arprot}),
              128'({8'(BL - 1), 3'd3, 2'b01, 1'b0, 4'b0011, 3'b000}));
`ifdef AXI_ID_EN
          chk("arid", 128'(arid), 128'(IDW'((e - BASE) / BB)));
`endif
        end
      end
      if (done && !done_prev) begin
        if (res_q.size() == 0) miss("done_unexpected");
        else begin
          re = res_q.pop_front();
          $display("RUN done err_count=%0d pass=%0d", err_count, pass);
          chk("err_count", 128'(err_count), 128'(re.err));
          chk("pass_busy", 128'({pass, busy}), 128'({re.pass, 1'b0}));
        end
      end
      done_prev = done;
    end
  end

  task automatic flush_queues();
    aw_q.delete(); w_q.delete(); ar_q.delete(); res_q.delete();
  endtask

  task automatic check_outputs_zero(string tag);
    chk({tag, "_ctrl"}, 128'({busy, done, pass, err_count, awvalid, wvalid, wlast, wstrb,
                              bready, arvalid, rready, awlen, awsize, awburst, awlock,
                              awcache, awprot, arlen, arsize, arburst, arlock, arcache,
                              arprot}), 128'(0));
    chk({tag, "_data"}, 128'({awaddr, araddr, wdata}), 128'(0));
  endtask

  task automatic push_run(input int exp_err);
    logic [31:0] a;
    res_t r;
    for (int k = 0; k < NB; k++) begin
      aw_q.push_back(BASE + 32'(k * BB));
      ar_q.push_back(BASE + 32'(k * BB));
      for (int b = 0; b < BL; b++) begin
        a = BASE + 32'(k * BB + b * BYTES);
        w_q.push_back('{data: model_beat(a), last: (b == BL - 1)});
      end
    end
    r.err  = 16'(exp_err);
    r.pass = (exp_err == 0);
    res_q.push_back(r);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic recover();
    rst_n = 0;
    flush_queues();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic run_one(input int exp_err, input bit early_start);
    int cnt;
    push_run(exp_err);
    pulse_start();
    chk("start_accept", 128'({busy, done, pass, err_count}), 128'({1'b1, 1'b0, 1'b0, 16'd0}));
    if (early_start) begin
      repeat (3) @(posedge clk);
      #1 start = 1;
      @(posedge clk);
      #1 start = 0;
    end
    cnt = 0;
    while (!done && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    if (!done) begin
      miss("run_timeout");
      recover();
    end else begin
      @(negedge clk);
      chk("queues_drained", 128'(aw_q.size() + w_q.size() + ar_q.size() + res_q.size()),
          128'(0));
      chk("done_held", 128'({done, busy}), 128'({1'b1, 1'b0}));
    end
  endtask

  initial begin
    int cnt;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(posedge clk);
    #1 rst_n = 1;

    run_one(0, 0);                                   // ideal slave
    stall_en = 1;
    for (int i = 0; i < 3; i++) run_one(0, 0);       // random stalls
    stall_en = 0; corrupt_en = 1;
    run_one(1, 0);                                   // rdata bit 0 flipped once
    corrupt_en = 0; badresp_en = 1;
    run_one(NB + NB * BL, 0);                        // every B and R response SLVERR
    badresp_en = 0; stall_en = 1;
    run_one(0, 1);                                   // start while busy is ignored
    stall_en = 0;

    // Reset in the middle of W beat 2 of burst 0
    push_run(0);
    pulse_start();
    cnt = 0;
    while (!(s_waddr == BASE && s_wbeat == 2 && wvalid) && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 200) miss("reset_point_timeout");
    #1 rst_n = 0;
    @(posedge clk);
    #1;
    check_outputs_zero("reset_mid_burst");
    flush_queues();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    run_one(0, 0);

`ifdef AXI_ID_EN
    badid_en = 1;
    run_one(1, 1);
    badid_en = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
